// File: rtl/fsm_cmd_scheduler_if.sv
// Request/command bus between the switch panel / auto-demo control and the
// command scheduler that drives the counter/shift-register datapath.
interface fsm_cmd_scheduler_if;

  // Manual requester and auto-program enable
  logic       man_req;
  logic [2:0] man_cmd;
  logic [3:0] man_value;
  logic       auto_en;

  // Scheduler results and datapath controls
  logic       man_ack;
  logic       enable;
  logic       check;
  logic       mode;
  logic       direction;
  logic [3:0] value;
  logic [2:0] auto_step;
  logic       overrun;

  modport master (
    output man_req,
    output man_cmd,
    output man_value,
    output auto_en,
    input  man_ack,
    input  enable,
    input  check,
    input  mode,
    input  direction,
    input  value,
    input  auto_step,
    input  overrun
  );

  modport slave (
    input  man_req,
    input  man_cmd,
    input  man_value,
    input  auto_en,
    output man_ack,
    output enable,
    output check,
    output mode,
    output direction,
    output value,
    output auto_step,
    output overrun
  );

endinterface

// File: rtl/fsm_cmd_scheduler.sv
// Arbitrates manual (req/ack) and auto-demo commands onto the datapath,
// issuing at most one single-cycle enable pulse per clock.
module fsm_cmd_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fsm_cmd_scheduler_if.slave   bus
);

  localparam int unsigned CMD_W  = 7;
  localparam int unsigned STEP_W = 3;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_man_grant;
  logic                w_auto_grant;
  logic                w_tick;
  logic [CMD_W-1:0]    w_auto_cmd;

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_pending;
  logic                r_overrun;
  logic [STEP_W-1:0]   r_auto_step;

  logic                r_enable;
  logic                r_man_ack;
  logic                r_check;
  logic                r_mode;
  logic                r_direction;
  logic [3:0]          r_value;

  // Auto-demo program: {check, mode, direction, value}
  function automatic logic [CMD_W-1:0] auto_entry(input logic [STEP_W-1:0] idx);
    logic [CMD_W-1:0] cmd;
    cmd = '0;
    case (idx)
      3'd0:    cmd = {1'b1, 1'b0, 1'b0, 4'h0};
      3'd1:    cmd = {1'b0, 1'b0, 1'b0, 4'h0};
      3'd2:    cmd = {1'b0, 1'b0, 1'b0, 4'h0};
      3'd3:    cmd = {1'b0, 1'b1, 1'b0, 4'h4};
      3'd4:    cmd = {1'b0, 1'b1, 1'b0, 4'h4};
      3'd5:    cmd = {1'b0, 1'b1, 1'b1, 4'h1};
      3'd6:    cmd = {1'b0, 1'b0, 1'b1, 4'h0};
      3'd7:    cmd = {1'b0, 1'b0, 1'b1, 4'h0};
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

  // Manual handshake state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake next state and per-cycle arbitration (manual beats auto)
  always_comb begin
    w_state_nxt  = r_state;
    w_man_grant  = 1'b0;
    w_auto_grant = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.man_req) begin
          w_man_grant = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!bus.man_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A pending auto command is discarded, not issued, once auto_en drops
    w_auto_grant = r_pending && bus.auto_en && !w_man_grant;
  end

  assign w_tick     = bus.auto_en && (r_div_cnt == TICK_LAST);
  assign w_auto_cmd = auto_entry(r_auto_step);

  // Tick divider: free-runs 0..TICK_DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (!bus.auto_en || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // One-deep auto request; a tick arriving while it is full is lost
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (!bus.auto_en) begin
      r_pending <= 1'b0;
    end else if (w_tick && !r_pending) begin
      r_pending <= 1'b1;
    end else if (w_auto_grant) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (w_tick && r_pending) begin
      r_overrun <= 1'b1;
    end
  end

  // Program pointer wraps 7 -> 0 through natural 3-bit overflow
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_auto_step <= '0;
    end else if (!bus.auto_en) begin
      r_auto_step <= '0;
    end else if (w_auto_grant) begin
      r_auto_step <= r_auto_step + STEP_W'(1);
    end
  end

  // Datapath controls hold the last issued command between pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_enable    <= 1'b0;
      r_man_ack   <= 1'b0;
      r_check     <= 1'b0;
      r_mode      <= 1'b0;
      r_direction <= 1'b0;
      r_value     <= '0;
    end else begin
      r_enable  <= w_man_grant || w_auto_grant;
      r_man_ack <= w_man_grant;
      if (w_man_grant) begin
        {r_check, r_mode, r_direction} <= bus.man_cmd;
        r_value                        <= bus.man_value;
      end else if (w_auto_grant) begin
        {r_check, r_mode, r_direction, r_value} <= w_auto_cmd;
      end
    end
  end

  assign bus.man_ack   = r_man_ack;
  assign bus.enable    = r_enable;
  assign bus.check     = r_check;
  assign bus.mode      = r_mode;
  assign bus.direction = r_direction;
  assign bus.value     = r_value;
  assign bus.auto_step = r_auto_step;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_fsm_cmd_scheduler.sv
// Bench for fsm_cmd_scheduler: two instances (TICK_DIV 4 and 2) share stimulus
// and are compared every cycle against a behavioural model, plus directed cases.
module tb_fsm_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic       req;
  logic [2:0] cmd;
  logic [3:0] val;
  logic       aen;

  int errors = 0;
  int checks = 0;

  fsm_cmd_scheduler_if if4 ();
  fsm_cmd_scheduler_if if2 ();

  assign if4.man_req   = req;
  assign if4.man_cmd   = cmd;
  assign if4.man_value = val;
  assign if4.auto_en   = aen;
  assign if2.man_req   = req;
  assign if2.man_cmd   = cmd;
  assign if2.man_value = val;
  assign if2.auto_en   = aen;

  fsm_cmd_scheduler #(.TICK_DIV(4), .DIV_W(3)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4));
  fsm_cmd_scheduler #(.TICK_DIV(2), .DIV_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Auto program as listed: {check, mode, direction, value}
  logic [6:0] prog [8] = '{7'b1000000, 7'b0000000, 7'b0000000, 7'b0100100,
                           7'b0100100, 7'b0110001, 7'b0010000, 7'b0010000};

  // Behavioural model state, index 0 -> TICK_DIV 4, index 1 -> TICK_DIV 2
  bit         m_armed [2];
  bit         m_skip  [2];
  int         m_en_cnt[2];
  bit         m_pend  [2];
  int         m_step  [2];
  bit         m_ovr   [2];
  bit         m_en    [2];
  bit         m_ack   [2];
  logic [6:0] m_ctl   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    for (int d = 0; d < 2; d++) begin
      m_armed[d] = 1'b1; m_skip[d] = 1'b0; m_en_cnt[d] = 0; m_pend[d] = 1'b0;
      m_step[d] = 0; m_ovr[d] = 1'b0; m_en[d] = 1'b0; m_ack[d] = 1'b0; m_ctl[d] = '0;
    end
  endtask

  // One clock edge of the scheduling rules, using the inputs seen at that edge
  task model_update();
    for (int d = 0; d < 2; d++) begin
      int period;
      bit man, auto_g, tick, npend;
      period = (d == 0) ? 4 : 2;
      man    = m_armed[d] && req;
      auto_g = m_pend[d] && aen && !man;
      tick   = aen && ((m_en_cnt[d] % period) == period - 1);
      if (tick && m_pend[d]) m_ovr[d] = 1'b1;
      npend  = aen && ((m_pend[d] && !auto_g) || (tick && !m_pend[d]));
      m_en[d]  = man || auto_g;
      m_ack[d] = man;
      if (man) m_ctl[d] = {cmd, val};
      else if (auto_g) m_ctl[d] = prog[m_step[d]];
      if (!aen) m_step[d] = 0;
      else if (auto_g) m_step[d] = (m_step[d] + 1) % 8;
      // After an issue the first following edge is ignored; then req must be seen low
      if (man) begin
        m_armed[d] = 1'b0; m_skip[d] = 1'b1;
      end else if (!m_armed[d]) begin
        if (m_skip[d]) m_skip[d] = 1'b0;
        else if (!req) m_armed[d] = 1'b1;
      end
      m_en_cnt[d] = aen ? m_en_cnt[d] + 1 : 0;
      m_pend[d]   = npend;
    end
  endtask

  function automatic logic [12:0] exp_out(input int d);
    return {m_ack[d], m_en[d], m_ctl[d], 3'(m_step[d]), m_ovr[d]};
  endfunction

  function automatic logic [12:0] dut_out(input int d);
    if (d == 0)
      return {if4.man_ack, if4.enable, if4.check, if4.mode, if4.direction, if4.value,
              if4.auto_step, if4.overrun};
    return {if2.man_ack, if2.enable, if2.check, if2.mode, if2.direction, if2.value,
            if2.auto_step, if2.overrun};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("model_dut4", 32'(dut_out(0)), 32'(exp_out(0)));
    chk("model_dut2", 32'(dut_out(1)), 32'(exp_out(1)));
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset_dut4", 32'(dut_out(0)), 32'd0);
    chk("reset_dut2", 32'(dut_out(1)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       req;
    logic [2:0] cmd;
    logic [3:0] val;
    logic       en;
    logic       ack;
    logic [2:0] ctl;
    logic [3:0] v;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [6:0] seq [$];
    int         cyc [$];
    logic [2:0] prev_step;
    bit         wrapped;
    int         first_en;
    int         n_en;

    tbl[0]  = '{1'b1, 3'b010, 4'h5, 1'b1, 1'b1, 3'b010, 4'h5};
    tbl[1]  = '{1'b1, 3'b010, 4'h5, 1'b0, 1'b0, 3'b010, 4'h5};
    tbl[2]  = '{1'b1, 3'b010, 4'h5, 1'b0, 1'b0, 3'b010, 4'h5};
    tbl[3]  = '{1'b1, 3'b010, 4'h5, 1'b0, 1'b0, 3'b010, 4'h5};
    tbl[4]  = '{1'b1, 3'b010, 4'h5, 1'b0, 1'b0, 3'b010, 4'h5};
    tbl[5]  = '{1'b0, 3'b010, 4'h5, 1'b0, 1'b0, 3'b010, 4'h5};
    tbl[6]  = '{1'b1, 3'b101, 4'hA, 1'b1, 1'b1, 3'b101, 4'hA};
    tbl[7]  = '{1'b0, 3'b101, 4'hA, 1'b0, 1'b0, 3'b101, 4'hA};
    tbl[8]  = '{1'b0, 3'b101, 4'hA, 1'b0, 1'b0, 3'b101, 4'hA};
    tbl[9]  = '{1'b1, 3'b011, 4'h3, 1'b1, 1'b1, 3'b011, 4'h3};
    tbl[10] = '{1'b0, 3'b011, 4'h3, 1'b0, 1'b0, 3'b011, 4'h3};

    rst = 1'b1; req = 1'b0; cmd = '0; val = '0; aen = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Manual handshake vectors, auto program off
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; cmd = tbl[i].cmd; val = tbl[i].val;
      cycle();
      chk($sformatf("tbl%0d", i),
          32'({if4.enable, if4.man_ack, if4.check, if4.mode, if4.direction, if4.value}),
          32'({tbl[i].en, tbl[i].ack, tbl[i].ctl, tbl[i].v}));
    end

    // Auto program alone for 40 cycles
    req = 1'b0;
    do_reset();
    aen = 1'b1; prev_step = '0; wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (if4.enable) begin
        seq.push_back({if4.check, if4.mode, if4.direction, if4.value});
        cyc.push_back(i);
      end
      if (prev_step == 3'd7 && if4.auto_step == 3'd0) wrapped = 1'b1;
      prev_step = if4.auto_step;
    end
    chk("auto_count", 32'(seq.size()), 32'd9);
    for (int i = 0; i < seq.size() && i < 9; i++)
      chk($sformatf("auto_entry%0d", i), 32'(seq[i]), 32'(prog[i % 8]));
    if (cyc.size() > 0) chk("auto_first", 32'(cyc[0]), 32'd4);
    for (int i = 1; i < cyc.size(); i++)
      chk($sformatf("auto_gap%0d", i), 32'(cyc[i] - cyc[i-1]), 32'd4);
    chk("auto_wrap", 32'(wrapped), 32'd1);

    // Manual request arriving on the tick cycle: manual then auto back-to-back
    aen = 1'b0;
    do_reset();
    aen = 1'b1; cmd = 3'b001; val = 4'h9;
    for (int i = 0; i < 7; i++) begin
      req = (i == 3);
      cycle();
      if (i == 3)
        chk("collide_man", 32'({if4.enable, if4.man_ack, if4.check, if4.mode, if4.direction,
            if4.value}), 32'({2'b11, 3'b001, 4'h9}));
      if (i == 4)
        chk("collide_auto", 32'({if4.enable, if4.man_ack, if4.check, if4.mode, if4.direction,
            if4.value}), 32'({2'b10, prog[0]}));
    end
    chk("collide_ovr", 32'(if4.overrun), 32'd0);

    // TICK_DIV 2: manual grant defers pending across the next tick
    aen = 1'b0; req = 1'b0;
    do_reset();
    aen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req = (i == 2);
      cycle();
      if (i == 3) chk("ovr_set", 32'(if2.overrun), 32'd1);
    end
    chk("ovr_sticky", 32'(if2.overrun), 32'd1);
    chk("ovr_none4", 32'(if4.overrun), 32'd0);
    do_reset();
    chk("ovr_clear", 32'(if2.overrun), 32'd0);

    // auto_en dropped the cycle after a tick, then re-enabled
    aen = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    aen = 1'b0; n_en = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (if4.enable) n_en++;
      chk("drop_step", 32'(if4.auto_step), 32'd0);
    end
    chk("drop_noen", 32'(n_en), 32'd0);
    aen = 1'b1; first_en = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (if4.enable && first_en < 0) first_en = i;
    end
    chk("reen_first", 32'(first_en), 32'd4);

    // Reset during ACK with request still held
    aen = 1'b0;
    do_reset();
    req = 1'b1; cmd = 3'b110; val = 4'h7;
    cycle();
    chk("ack_before", 32'({if4.enable, if4.man_ack}), 32'({2'b11}));
    #2;
    do_reset();
    cycle();
    chk("ack_reissue", 32'({if4.enable, if4.man_ack, if4.check, if4.mode, if4.direction,
        if4.value}), 32'({2'b11, 3'b110, 4'h7}));

    // Randomized traffic, both instances against the model
    req = 1'b0; aen = 1'b1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (req) begin
        if ($urandom_range(0, 3) == 0) req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req = 1'b1;
        cmd = 3'($urandom_range(0, 7));
        val = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) aen = ~aen;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
